// File: rtl/control_unit.sv
// Multicycle control FSM: sequences fetch, decode, execute, memory and write-back
// steps and drives the datapath control lines combinationally from the current state.
module control_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Inst,
   input  logic        Zero,
   input  logic        i_ack,
   input  logic        d_ack,
   output logic        PCWrite,
   output logic        PCWriteCond,
   output logic        BranchNe,
   output logic        IRWrite,
   output logic        IMemReq,
   output logic        DMemReq,
   output logic        DMemWe,
   output logic        RegWrite,
   output logic        LoadAB,
   output logic        LoadALUOut,
   output logic        LoadMDR,
   output logic        Illegal,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [2:0]  ALUCtl,
   output logic [1:0]  MemToReg,
   output logic [1:0]  PCSource,
   output logic [3:0]  State
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EXEC_R   = 4'd3,
      S_EXEC_I   = 4'd4,
      S_LUI      = 4'd5,
      S_WB_ALU   = 4'd6,
      S_MEM_ADDR = 4'd7,
      S_MEM_RD   = 4'd8,
      S_WB_MEM   = 4'd9,
      S_MEM_WR   = 4'd10,
      S_BRANCH   = 4'd11,
      S_JAL      = 4'd12,
      S_JALR     = 4'd13,
      S_HALT     = 4'd14
   } state_t;

   state_t state_q, state_d;

   logic [6:0] opcode;
   logic [2:0] funct3;
   assign opcode = Inst[6:0];
   assign funct3 = Inst[14:12];

   // Zero is consumed by the datapath branch gate, not by this decoder.
   logic zero_unused, inst_unused;
   assign zero_unused = Zero;
   assign inst_unused = ^{Inst[31], Inst[29:15], Inst[11:7]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      BranchNe    = 1'b0;
      IRWrite     = 1'b0;
      IMemReq     = 1'b0;
      DMemReq     = 1'b0;
      DMemWe      = 1'b0;
      RegWrite    = 1'b0;
      LoadAB      = 1'b0;
      LoadALUOut  = 1'b0;
      LoadMDR     = 1'b0;
      Illegal     = 1'b0;
      ALUSrcA     = 2'b00;
      ALUSrcB     = 2'b00;
      ALUCtl      = 3'b000;
      MemToReg    = 2'b00;
      PCSource    = 2'b00;

      case (state_q)
         S_IDLE: state_d = S_FETCH;

         S_FETCH: begin
            IMemReq = 1'b1;
            if (i_ack) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               ALUSrcB = 2'b01;
               state_d = S_DECODE;
            end
         end

         // Precompute OldPC + imm as the branch/JAL target while decoding.
         S_DECODE: begin
            LoadAB     = 1'b1;
            LoadALUOut = 1'b1;
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b10;
            case (opcode)
               7'b0110011: state_d = S_EXEC_R;
               7'b0010011: state_d = S_EXEC_I;
               7'b0110111: state_d = S_LUI;
               7'b0000011,
               7'b0100011: state_d = S_MEM_ADDR;
               7'b1100011: state_d = (funct3 == 3'b000 || funct3 == 3'b001) ? S_BRANCH : S_HALT;
               7'b1101111: state_d = S_JAL;
               7'b1100111: state_d = (funct3 == 3'b000) ? S_JALR : S_HALT;
               default:    state_d = S_HALT;
            endcase
         end

         S_EXEC_R: begin
            ALUSrcA    = 2'b01;
            ALUCtl     = Inst[30] ? 3'b001 : 3'b000;
            LoadALUOut = 1'b1;
            state_d    = S_WB_ALU;
         end

         S_EXEC_I: begin
            ALUSrcA    = 2'b01;
            ALUSrcB    = 2'b10;
            LoadALUOut = 1'b1;
            state_d    = S_WB_ALU;
         end

         S_LUI: begin
            ALUSrcB    = 2'b10;
            ALUCtl     = 3'b010;
            LoadALUOut = 1'b1;
            state_d    = S_WB_ALU;
         end

         S_WB_ALU: begin
            RegWrite = 1'b1;
            state_d  = S_FETCH;
         end

         S_MEM_ADDR: begin
            ALUSrcA    = 2'b01;
            ALUSrcB    = 2'b10;
            LoadALUOut = 1'b1;
            state_d    = Inst[5] ? S_MEM_WR : S_MEM_RD;
         end

         S_MEM_RD: begin
            DMemReq = 1'b1;
            if (d_ack) begin
               LoadMDR = 1'b1;
               state_d = S_WB_MEM;
            end
         end

         S_WB_MEM: begin
            RegWrite = 1'b1;
            MemToReg = 2'b01;
            state_d  = S_FETCH;
         end

         S_MEM_WR: begin
            DMemReq = 1'b1;
            DMemWe  = 1'b1;
            if (d_ack) state_d = S_FETCH;
         end

         S_BRANCH: begin
            ALUSrcA     = 2'b01;
            ALUCtl      = 3'b001;
            PCWriteCond = 1'b1;
            BranchNe    = Inst[12];
            PCSource    = 2'b01;
            state_d     = S_FETCH;
         end

         S_JAL: begin
            RegWrite = 1'b1;
            MemToReg = 2'b10;
            PCWrite  = 1'b1;
            PCSource = 2'b01;
            state_d  = S_FETCH;
         end

         S_JALR: begin
            ALUSrcA  = 2'b01;
            ALUSrcB  = 2'b10;
            RegWrite = 1'b1;
            MemToReg = 2'b10;
            PCWrite  = 1'b1;
            PCSource = 2'b10;
            state_d  = S_FETCH;
         end

         S_HALT: Illegal = 1'b1;

         default: state_d = S_IDLE;
      endcase
   end

   assign State = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class through the FSM
// and checks state and every control output against hand-written expectations.
module tb_control_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Inst;
   logic        Zero;
   logic        i_ack, d_ack;
   logic        PCWrite, PCWriteCond, BranchNe, IRWrite, IMemReq, DMemReq, DMemWe;
   logic        RegWrite, LoadAB, LoadALUOut, LoadMDR, Illegal;
   logic [1:0]  ALUSrcA, ALUSrcB, MemToReg, PCSource;
   logic [2:0]  ALUCtl;
   logic [3:0]  State;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   control_unit dut (
      .clk(clk), .reset(reset), .Inst(Inst), .Zero(Zero), .i_ack(i_ack), .d_ack(d_ack),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe), .IRWrite(IRWrite),
      .IMemReq(IMemReq), .DMemReq(DMemReq), .DMemWe(DMemWe), .RegWrite(RegWrite),
      .LoadAB(LoadAB), .LoadALUOut(LoadALUOut), .LoadMDR(LoadMDR), .Illegal(Illegal),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUCtl(ALUCtl), .MemToReg(MemToReg),
      .PCSource(PCSource), .State(State)
   );

   localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3,
      S_EXEC_I = 4'd4, S_LUI = 4'd5, S_WB_ALU = 4'd6, S_MEM_ADDR = 4'd7, S_MEM_RD = 4'd8,
      S_WB_MEM = 4'd9, S_MEM_WR = 4'd10, S_BRANCH = 4'd11, S_JAL = 4'd12, S_JALR = 4'd13,
      S_HALT = 4'd14;

   // All control outputs packed into one word for whole-vector comparison.
   logic [22:0] outs;
   assign outs = {PCWrite, PCWriteCond, BranchNe, IRWrite, IMemReq, DMemReq, DMemWe,
                  RegWrite, LoadAB, LoadALUOut, LoadMDR, Illegal,
                  ALUSrcA, ALUSrcB, ALUCtl, MemToReg, PCSource};

   localparam logic [22:0] PCW  = 23'd1 << 22, PWC  = 23'd1 << 21, BNE  = 23'd1 << 20,
                           IRW  = 23'd1 << 19, IMR  = 23'd1 << 18, DMR  = 23'd1 << 17,
                           DWE  = 23'd1 << 16, RW   = 23'd1 << 15, LAB  = 23'd1 << 14,
                           LALU = 23'd1 << 13, LMDR = 23'd1 << 12, ILL  = 23'd1 << 11;

   function automatic logic [22:0] sa (input logic [1:0] v);  return {12'b0, v, 9'b0}; endfunction
   function automatic logic [22:0] sb (input logic [1:0] v);  return {14'b0, v, 7'b0}; endfunction
   function automatic logic [22:0] ctl(input logic [2:0] v);  return {16'b0, v, 4'b0}; endfunction
   function automatic logic [22:0] mtr(input logic [1:0] v);  return {19'b0, v, 2'b0}; endfunction
   function automatic logic [22:0] pcs(input logic [1:0] v);  return {21'b0, v};       endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Let combinational outputs settle on the current inputs, then compare.
   task automatic expect_cyc(input string tag, input logic [3:0] st, input logic [22:0] o);
      #1;
      check({tag, ".state"}, {28'b0, State}, {28'b0, st});
      check({tag, ".outs"},  {9'b0, outs},   {9'b0, o});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   localparam logic [22:0] O_FETCH_ACK = PCW | IRW | IMR | sb(2'b01);
   localparam logic [22:0] O_DECODE    = LAB | LALU | sa(2'b10) | sb(2'b10);
   localparam logic [22:0] O_ADDR      = sa(2'b01) | sb(2'b10) | LALU;

   initial begin
      reset = 1'b1; Inst = 32'h00500093; Zero = 1'b0; i_ack = 1'b1; d_ack = 1'b0;
      expect_cyc("reset", S_IDLE, 23'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      expect_cyc("idle_after_reset", S_IDLE, 23'd0);

      // addi x1,x0,5
      step(); expect_cyc("addi.fetch",  S_FETCH,  O_FETCH_ACK);
      step(); expect_cyc("addi.decode", S_DECODE, O_DECODE);
      step(); expect_cyc("addi.exec_i", S_EXEC_I, O_ADDR);
      step(); expect_cyc("addi.wb",     S_WB_ALU, RW);
      step();

      // load with a stalled fetch and three wait cycles in MEM_RD
      i_ack = 1'b0; Inst = 32'h0000B103;
      expect_cyc("ld.fetch_wait0", S_FETCH, IMR);
      step(); expect_cyc("ld.fetch_wait1", S_FETCH, IMR);
      i_ack = 1'b1;
      expect_cyc("ld.fetch_ack", S_FETCH, O_FETCH_ACK);
      step(); i_ack = 1'b0;
      expect_cyc("ld.decode", S_DECODE, O_DECODE);
      step(); expect_cyc("ld.addr", S_MEM_ADDR, O_ADDR);
      for (int i = 0; i < 3; i++) begin
         step(); expect_cyc($sformatf("ld.rd_wait%0d", i), S_MEM_RD, DMR);
      end
      d_ack = 1'b1;
      expect_cyc("ld.rd_ack", S_MEM_RD, DMR | LMDR);
      step(); d_ack = 1'b0;
      expect_cyc("ld.wb_mem", S_WB_MEM, RW | mtr(2'b01));
      step();

      // store: stray i_ack/d_ack in DECODE, then async reset mid-wait in MEM_WR
      i_ack = 1'b1; Inst = 32'h0020B023;
      expect_cyc("sd.fetch", S_FETCH, O_FETCH_ACK);
      step(); d_ack = 1'b1;
      expect_cyc("sd.decode_stray_ack", S_DECODE, O_DECODE);
      step(); d_ack = 1'b0;
      expect_cyc("sd.addr", S_MEM_ADDR, O_ADDR);
      step(); expect_cyc("sd.wr_wait", S_MEM_WR, DMR | DWE);
      reset = 1'b1;
      expect_cyc("sd.async_reset", S_IDLE, 23'd0);
      #1 reset = 1'b0;
      step(); expect_cyc("post_reset.fetch", S_FETCH, O_FETCH_ACK);

      // store completing normally
      step(); step(); step(); d_ack = 1'b1;
      expect_cyc("sd.wr_ack", S_MEM_WR, DMR | DWE);
      step(); d_ack = 1'b0;
      expect_cyc("sd.back_to_fetch", S_FETCH, O_FETCH_ACK);

      // bne
      Inst = 32'h00209463;
      step(); step();
      expect_cyc("bne.branch", S_BRANCH, sa(2'b01) | ctl(3'b001) | PWC | BNE | pcs(2'b01));
      step(); expect_cyc("bne.fetch", S_FETCH, O_FETCH_ACK);

      // sub x0,x1,x2
      Inst = 32'h40208033;
      step(); step();
      expect_cyc("sub.exec_r", S_EXEC_R, sa(2'b01) | ctl(3'b001) | LALU);
      step(); step();

      // lui
      Inst = 32'h000010B7;
      step(); step();
      expect_cyc("lui.exec", S_LUI, sb(2'b10) | ctl(3'b010) | LALU);
      step(); step();

      // jal
      Inst = 32'h0000006F;
      step(); step();
      expect_cyc("jal.exec", S_JAL, RW | mtr(2'b10) | PCW | pcs(2'b01));
      step();

      // jalr
      Inst = 32'h000000E7;
      step(); step();
      expect_cyc("jalr.exec", S_JALR, sa(2'b01) | sb(2'b10) | RW | mtr(2'b10) | PCW | pcs(2'b10));
      step();

      // illegal opcode: HALT is sticky regardless of acks
      Inst = 32'h0000107F;
      step(); step();
      expect_cyc("ill.halt", S_HALT, ILL);
      for (int i = 0; i < 10; i++) begin
         d_ack = i[0];
         step(); expect_cyc($sformatf("ill.hold%0d", i), S_HALT, ILL);
      end
      d_ack = 1'b0;
      reset = 1'b1;
      expect_cyc("ill.reset", S_IDLE, 23'd0);
      #1 reset = 1'b0;
      step(); expect_cyc("ill.refetch", S_FETCH, O_FETCH_ACK);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have inputs Inst [31:0] (instruction register contents), Zero [1] (ALU zero flag), i_ack [1] (instruction memory done) and d_ack [1] (data memory done).
REQ-004 SHALL have 1-bit outputs PCWrite, PCWriteCond, BranchNe, IRWrite, IMemReq, DMemReq, DMemWe, RegWrite, LoadAB, LoadALUOut, LoadMDR and Illegal.
REQ-005 SHALL have 2-bit output ALUSrcA: 00 = PC, 01 = A register (rs1), 10 = OldPC.
REQ-006 SHALL have 2-bit output ALUSrcB: 00 = B register (rs2), 01 = constant 4, 10 = sign-extended immediate.
REQ-007 SHALL have 3-bit output ALUCtl: 000 = add, 001 = sub, 010 = pass B.
REQ-008 SHALL have 2-bit output MemToReg: 00 = ALUOut, 01 = MDR, 10 = PC.
REQ-009 SHALL have 2-bit output PCSource: 00 = live ALU result, 01 = ALUOut, 10 = live ALU result with bit 0 cleared.
REQ-010 SHALL have 4-bit output State: the current state encoding, for debug.

Function
REQ-011 SHALL be a multicycle FSM with states IDLE, FETCH, DECODE, EXEC_R, EXEC_I, LUI, WB_ALU, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, JAL, JALR and HALT.
REQ-012 SHALL decode outputs combinationally from State, Inst, i_ack and d_ack only; any output not listed for a state is 0.
REQ-013 IDLE: all outputs 0; next state is FETCH unconditionally.
REQ-014 FETCH: IMemReq=1.
- If i_ack=1 in the same cycle (zero-wait legal): IRWrite=1, PCWrite=1, ALUSrcA=00, ALUSrcB=01, ALUCtl=000, PCSource=00; next DECODE.
- Otherwise: stay in FETCH.
REQ-015 DECODE: LoadAB=1, LoadALUOut=1, ALUSrcA=10, ALUSrcB=10, ALUCtl=000. Next state by Inst[6:0]:
- 0110011 -> EXEC_R; 0010011 -> EXEC_I; 0110111 -> LUI
- 0000011 or 0100011 -> MEM_ADDR
- 1100011 with funct3 000/001 -> BRANCH
- 1101111 -> JAL; 1100111 with funct3 000 -> JALR
- anything else -> HALT
REQ-016 EXEC_R: ALUSrcA=01, ALUSrcB=00, ALUCtl=001 if Inst[30]=1 else 000, LoadALUOut=1; next WB_ALU.
REQ-017 EXEC_I: ALUSrcA=01, ALUSrcB=10, ALUCtl=000, LoadALUOut=1; next WB_ALU.
REQ-018 LUI: ALUSrcB=10, ALUCtl=010, LoadALUOut=1; next WB_ALU.
REQ-019 WB_ALU: RegWrite=1, MemToReg=00; next FETCH.
REQ-020 MEM_ADDR: ALUSrcA=01, ALUSrcB=10, ALUCtl=000, LoadALUOut=1; next MEM_RD if Inst[5]=0, else MEM_WR.
REQ-021 MEM_RD: DMemReq=1; on d_ack=1, LoadMDR=1 and next WB_MEM; else stay.
REQ-022 WB_MEM: RegWrite=1, MemToReg=01; next FETCH.
REQ-023 MEM_WR: DMemReq=1, DMemWe=1; on d_ack=1 next FETCH; else stay.
REQ-024 BRANCH: ALUSrcA=01, ALUSrcB=00, ALUCtl=001, PCWriteCond=1, BranchNe=Inst[12], PCSource=01; next FETCH.
- The datapath loads PC when PCWriteCond & (Zero ^ BranchNe).
REQ-025 JAL: RegWrite=1, MemToReg=10, PCWrite=1, PCSource=01; next FETCH.
REQ-026 JALR: ALUSrcA=01, ALUSrcB=10, ALUCtl=000, RegWrite=1, MemToReg=10, PCWrite=1, PCSource=10; next FETCH.
REQ-027 HALT: Illegal=1, all other outputs 0; remain in HALT until reset.
REQ-028 SHALL ignore i_ack outside FETCH and d_ack outside MEM_RD/MEM_WR, with no effect on state or outputs.
REQ-029 SHALL hold IMemReq/DMemReq continuously from state entry until the acknowledging cycle; no request is dropped while waiting.

Reset
REQ-030 Asserting reset SHALL force State=IDLE immediately, without waiting for a clock edge; all outputs go 0 in that same cycle, including mid-wait in MEM_RD, MEM_WR or FETCH.
REQ-031 After reset deasserts, the first rising edge SHALL move IDLE to FETCH.

Verification
REQ-032 Reset, then i_ack=1 always, Inst=0x00500093 (addi x1,x0,5) -> states IDLE, FETCH, DECODE, EXEC_I, WB_ALU, FETCH; RegWrite=1 only in WB_ALU.
REQ-033 Inst=0x0000B103 (ld), d_ack held low 3 cycles in MEM_RD -> DMemReq=1 for 4 cycles, LoadMDR=1 only in the ack cycle, then WB_MEM with MemToReg=01.
REQ-034 Inst=0x00209463 (bne) -> BRANCH with ALUCtl=001, PCWriteCond=1, BranchNe=1.
REQ-035 Inst=0x000000E7 (jalr) -> JALR with PCSource=10, MemToReg=10; Inst=0x0000107F (illegal) -> HALT, Illegal=1, stays in HALT for 10 cycles until reset.
REQ-036 Reset pulse asserted between edges while in MEM_WR -> State=IDLE and DMemReq=0 before the next edge; i_ack pulse while in DECODE -> no effect.
